bus_resp_mux: RTL and testbench
===============================

BUS_RESP_MUX -- requirements
Module: bus_resp_mux

Interface
REQ-001 Parameter N_SLV, default 6: number of slave ports, 2..16.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 16: maximum data-phase wait cycles before a forced error, 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  1  master presents a valid address phase this cycle.
REQ-007 bSel  in  N_SLV  address-phase slave select from decoder; one-hot nominal.
REQ-008 s_rdata  in  N_SLV*DW  packed slave read data; slave i occupies bits [i*DW +: DW].
REQ-009 s_ready  in  N_SLV  per-slave data-phase completion.
REQ-010 s_err  in  N_SLV  per-slave error response, qualified by s_ready.
REQ-011 m_rdata  out  DW  read data to master.
REQ-012 m_ready  out  1  data phase completes this cycle / address phase accepted.
REQ-013 m_err  out  1  error response, valid only when m_ready=1.
REQ-014 sel_conflict  out  1  one-cycle pulse: accepted bSel had more than one bit set.

Function
REQ-015 Address phase accepted at a rising edge when req=1 and m_ready=1.
REQ-016 On acceptance, bSel is priority-encoded: lowest set bit wins; the index is captured into the data-phase register.
REQ-017 FSM states: IDLE, DATA, DFLT.
- IDLE -> DATA on acceptance with bSel != 0.
- IDLE -> DFLT on acceptance with bSel == 0.
- DATA -> IDLE on completion with no new acceptance; DATA -> DATA/DFLT on completion with simultaneous acceptance (back-to-back, zero bubble).
- DFLT always completes in one cycle; successor state follows the same rule as DATA.
REQ-018 IDLE: m_ready=1, m_rdata=0, m_err=0.
REQ-019 DATA, captured index k: m_rdata=s_rdata[k], m_ready=s_ready[k], m_err=s_ready[k]&s_err[k]; combinational from captured index, zero added latency.
REQ-020 DFLT: m_ready=1, m_err=1, m_rdata=0.
REQ-021 Wait counter: cleared on entry to DATA, increments each DATA cycle with s_ready[k]=0, saturates at TIMEOUT.
REQ-022 When the counter equals TIMEOUT and s_ready[k]=0: m_ready=1, m_err=1, m_rdata=0 that cycle; the phase ends; the slave's later s_ready is ignored.
REQ-023 s_ready[k] and timeout in the same cycle: the slave response wins (normal data, s_err passed through).
REQ-024 Inputs of non-selected slaves never affect outputs.
REQ-025 sel_conflict asserts in the cycle after an acceptance with popcount(bSel)>1; transfer proceeds to the lowest index.
REQ-026 req=0 with m_ready=1 leaves the FSM in or returns it to IDLE; bSel is ignored.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, index 0, counter 0, sel_conflict 0; outputs take IDLE values immediately.
REQ-028 Reset mid-DATA abandons the transfer with no error pulse; the first edge after deassertion may accept a new request.

Structure
REQ-029 Shared package bus_pkg holds the FSM state enum, the N_SLV/DW defaults and the index-width function clog2(N_SLV).
REQ-030 One sub-module, prio_onehot_enc, holds the parametrised lowest-bit priority encoder (index, any-valid, multi-hit outputs).

Verification
REQ-031 Single read: req=1, bSel=6'b000100, s_rdata[2]=32'hA5A5_0002, s_ready[2]=1 next cycle -> m_rdata=32'hA5A5_0002, m_ready=1, m_err=0 in the data cycle.
REQ-032 Wait states: slave 4 holds s_ready=0 for 3 cycles -> m_ready=0 for 3 cycles, then 1 with the slave's data; no m_err.
REQ-033 Timeout: TIMEOUT=16, slave 1 never ready -> m_ready=1, m_err=1, m_rdata=0 on the 17th data cycle; FSM returns to IDLE.
REQ-034 Default slave / conflict: bSel=0 -> one-cycle m_err=1, m_rdata=0; bSel=6'b101000 -> slave 3 served, sel_conflict pulses once.
REQ-035 Back-to-back plus reset: completion of slave 0 with req=1, bSel=slave 5 in the same cycle -> slave 5 data next cycle, no idle gap; rst_n=0 mid-wait -> outputs return to IDLE values asynchronously, no m_err.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus response multiplexer: FSM state
// encoding, default geometry and the index-width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DFLT = 2'd2
    } state_t;

    localparam int DEF_N_SLV = 6;
    localparam int DEF_DW    = 32;
    localparam int CNT_W     = 8;

    // Width needed to index n slaves; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 5; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_resp_mux_if.sv
// Master/slave-side bundle of the bus response multiplexer. The master side
// drives the address phase and the slave responses; the mux returns the response.
interface bus_resp_mux_if
    import bus_pkg::*;
#(
    parameter int N_SLV = DEF_N_SLV,
    parameter int DW    = DEF_DW
);
    // Handshake: an address phase (req, bSel) is accepted on a rising edge
    // where req=1 and m_ready=1; a data phase ends on an edge with m_ready=1,
    // and m_err/m_rdata are meaningful only in that cycle.
    logic                req;
    logic [N_SLV-1:0]    bSel;
    logic [N_SLV*DW-1:0] s_rdata;
    logic [N_SLV-1:0]    s_ready;
    logic [N_SLV-1:0]    s_err;
    logic [DW-1:0]       m_rdata;
    logic                m_ready;
    logic                m_err;
    logic                sel_conflict;

    modport master (
        output req, bSel, s_rdata, s_ready, s_err,
        input  m_rdata, m_ready, m_err, sel_conflict
    );

    modport slave (
        input  req, bSel, s_rdata, s_ready, s_err,
        output m_rdata, m_ready, m_err, sel_conflict
    );

endinterface

// File: rtl/prio_onehot_enc.sv
// Lowest-bit-wins priority encoder over a nominally one-hot select vector,
// also flagging "any bit set" and "more than one bit set".
module prio_onehot_enc
    import bus_pkg::*;
#(
    parameter int N  = DEF_N_SLV,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/bus_resp_mux.sv
// Data-phase response multiplexer: captures the decoded slave index at address
// acceptance and steers that slave's response to the master, with a default
// error slave and a wait-state timeout.
module bus_resp_mux
    import bus_pkg::*;
#(
    parameter int N_SLV   = DEF_N_SLV,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_resp_mux_if.slave bus,
    output state_t        dbg_state
);

    localparam int IW = clog2(N_SLV);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CNT_W-1:0]  cnt;
    logic              conflict_q;

    logic [IW-1:0]     enc_idx;
    logic              enc_any;
    logic              enc_multi;

    logic              sel_ready;
    logic              sel_err;
    logic [DW-1:0]     sel_data;
    logic              timeout_hit;

    logic              ready_c;
    logic              err_c;
    logic [DW-1:0]     rdata_c;
    logic              accept;

    prio_onehot_enc #(
        .N  (N_SLV),
        .IW (IW)
    ) u_enc (
        .vec   (bus.bSel),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // Only the captured slave can reach the outputs; all others are masked.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx == IW'(i)) begin
                sel_ready = bus.s_ready[i];
                sel_err   = bus.s_err[i];
                sel_data  = bus.s_rdata[i*DW +: DW];
            end
        end
    end

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT)) && !sel_ready;

    always_comb begin
        ready_c = 1'b1;
        err_c   = 1'b0;
        rdata_c = '0;
        case (state)
            ST_DATA: begin
                if (sel_ready) begin
                    ready_c = 1'b1;
                    err_c   = sel_err;
                    rdata_c = sel_data;
                end else if (timeout_hit) begin
                    ready_c = 1'b1;
                    err_c   = 1'b1;
                    rdata_c = '0;
                end else begin
                    ready_c = 1'b0;
                    err_c   = 1'b0;
                    rdata_c = sel_data;
                end
            end
            ST_DFLT: begin
                ready_c = 1'b1;
                err_c   = 1'b1;
                rdata_c = '0;
            end
            default: begin
                ready_c = 1'b1;
                err_c   = 1'b0;
                rdata_c = '0;
            end
        endcase
    end

    assign accept = bus.req && ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= accept && enc_multi;
            if (accept) begin
                state <= enc_any ? ST_DATA : ST_DFLT;
                idx   <= enc_idx;
                cnt   <= '0;
            end else if (ready_c) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (cnt != CNT_W'(TIMEOUT)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.m_ready      = ready_c;
    assign bus.m_err        = err_c;
    assign bus.m_rdata      = rdata_c;
    assign bus.sel_conflict = conflict_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_bus_resp_mux.sv
// Directed bench for bus_resp_mux: reads, wait states, timeout, default slave,
// select conflict, back-to-back phases and asynchronous reset.
module tb_bus_resp_mux;
    import bus_pkg::*;

    localparam int N_SLV = 6;
    localparam int DW    = 32;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     n_vec;
    int     n_err;

    bus_resp_mux_if #(.N_SLV(N_SLV), .DW(DW)) bus ();

    bus_resp_mux #(.N_SLV(N_SLV), .DW(DW), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_bus(input string tag, input logic er, input logic ee, input logic [DW-1:0] ed);
        n_vec++;
        assert ({bus.m_ready, bus.m_err, bus.m_rdata} === {er, ee, ed})
        else begin
            n_err++;
            $error("FAIL %s: got rdy=%b err=%b data=%h, exp rdy=%b err=%b data=%h",
                   tag, bus.m_ready, bus.m_err, bus.m_rdata, er, ee, ed);
        end
    endtask

    task automatic chk_state(input string tag, input state_t es);
        n_vec++;
        assert (dbg_state === es)
        else begin
            n_err++;
            $error("FAIL %s: got state=%0d, exp state=%0d", tag, dbg_state, es);
        end
    endtask

    task automatic chk_conf(input string tag, input logic ec);
        n_vec++;
        assert (bus.sel_conflict === ec)
        else begin
            n_err++;
            $error("FAIL %s: got sel_conflict=%b, exp %b", tag, bus.sel_conflict, ec);
        end
    endtask

    // Present one address phase from IDLE; returns at the start of its data cycle.
    task automatic issue(input logic [N_SLV-1:0] sel);
        next_cycle();
        bus.s_ready = '0;
        bus.s_err   = '0;
        bus.req     = 1'b1;
        bus.bSel    = sel;
        next_cycle();
        bus.req     = 1'b0;
        bus.bSel    = '0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.bSel    = '0;
        bus.s_ready = '0;
        bus.s_err   = '0;
        for (int i = 0; i < N_SLV; i++) bus.s_rdata[i*DW +: DW] = pat(i);

        // Reset values
        #3;
        chk_bus("reset_out", 1'b1, 1'b0, 32'h0);
        chk_state("reset_state", ST_IDLE);
        chk_conf("reset_conf", 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // Single read from slave 2
        issue(6'b000100);
        bus.s_ready[2] = 1'b1;
        settle();
        chk_bus("single_rd", 1'b1, 1'b0, 32'hA5A5_0002);
        chk_state("single_state", ST_DATA);
        next_cycle();
        bus.s_ready = '0;
        settle();
        chk_state("single_idle", ST_IDLE);
        chk_bus("single_idle_out", 1'b1, 1'b0, 32'h0);

        // Slave 4 with three wait states; other slaves shout ready/error meanwhile
        issue(6'b010000);
        for (int c = 0; c < 3; c++) begin
            bus.s_ready = 6'b101111;
            bus.s_err   = 6'b101111;
            settle();
            chk_bus("wait_state", 1'b0, 1'b0, 32'hA5A5_0004);
            next_cycle();
        end
        bus.s_ready = 6'b010000;
        bus.s_err   = 6'b000000;
        settle();
        chk_bus("wait_done", 1'b1, 1'b0, 32'hA5A5_0004);

        // Slave error passed through with data
        issue(6'b000010);
        bus.s_ready[1] = 1'b1;
        bus.s_err[1]   = 1'b1;
        settle();
        chk_bus("slave_err", 1'b1, 1'b1, 32'hA5A5_0001);

        // Timeout: slave 1 never ready, forced error on the 17th data cycle
        issue(6'b000010);
        for (int c = 1; c <= 16; c++) begin
            settle();
            chk_bus("to_wait", 1'b0, 1'b0, 32'hA5A5_0001);
            next_cycle();
        end
        settle();
        chk_bus("to_fire", 1'b1, 1'b1, 32'h0);
        next_cycle();
        bus.s_ready[1] = 1'b1;
        settle();
        chk_state("to_idle", ST_IDLE);
        chk_bus("to_late_ready", 1'b1, 1'b0, 32'h0);

        // Slave ready in the timeout cycle wins
        issue(6'b001000);
        for (int c = 1; c <= 16; c++) next_cycle();
        bus.s_ready[3] = 1'b1;
        settle();
        chk_bus("to_race", 1'b1, 1'b0, 32'hA5A5_0003);

        // Default slave on empty select, then DFLT -> DATA back-to-back
        issue(6'b000000);
        bus.req  = 1'b1;
        bus.bSel = 6'b000100;
        settle();
        chk_state("dflt_state", ST_DFLT);
        chk_bus("dflt_out", 1'b1, 1'b1, 32'h0);
        next_cycle();
        bus.req        = 1'b0;
        bus.bSel       = '0;
        bus.s_ready[2] = 1'b1;
        settle();
        chk_bus("dflt_b2b", 1'b1, 1'b0, 32'hA5A5_0002);

        // Conflicting select: slave 3 served, slave 5 ignored, one conflict pulse
        issue(6'b101000);
        bus.s_ready = 6'b101000;
        bus.s_err   = 6'b100000;
        settle();
        chk_conf("conf_pulse", 1'b1);
        chk_bus("conf_data", 1'b1, 1'b0, 32'hA5A5_0003);
        next_cycle();
        bus.s_ready = '0;
        bus.s_err   = '0;
        settle();
        chk_conf("conf_clear", 1'b0);

        // Back-to-back slave 0 -> slave 5 with no idle gap
        issue(6'b000001);
        bus.s_ready[0] = 1'b1;
        bus.req        = 1'b1;
        bus.bSel       = 6'b100000;
        settle();
        chk_bus("b2b_first", 1'b1, 1'b0, 32'hA5A5_0000);
        next_cycle();
        bus.req     = 1'b0;
        bus.bSel    = '0;
        bus.s_ready = 6'b100000;
        settle();
        chk_state("b2b_state", ST_DATA);
        chk_bus("b2b_second", 1'b1, 1'b0, 32'hA5A5_0005);

        // Asynchronous reset in the middle of a wait
        issue(6'b010000);
        settle();
        chk_bus("rst_wait", 1'b0, 1'b0, 32'hA5A5_0004);
        #1;
        rst_n = 1'b0;
        #1;
        chk_bus("rst_async_out", 1'b1, 1'b0, 32'h0);
        chk_state("rst_async_state", ST_IDLE);
        next_cycle();
        rst_n    = 1'b1;
        bus.req  = 1'b1;
        bus.bSel = 6'b000001;
        settle();
        chk_bus("rst_idle_accept", 1'b1, 1'b0, 32'h0);
        next_cycle();
        bus.req        = 1'b0;
        bus.bSel       = '0;
        bus.s_ready    = 6'b000001;
        settle();
        chk_bus("rst_post_read", 1'b1, 1'b0, 32'hA5A5_0000);

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
